// File: rtl/i2c_target_if.sv
// I2C target bus bundle: line levels in, open-drain enable out, byte-level
// receive/transmit handshake.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_taken;
    logic       busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  tx_data,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output tx_taken,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        output tx_data,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  tx_taken,
        input  busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with 7-bit address match. SCL/SDA are oversampled on clk through
// 2-flop synchronisers; received bytes pop out on rx_data/rx_valid, read bytes
// are fetched from tx_data with a tx_taken pulse.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    logic       r_scl_sync1, r_scl_sync2, r_scl_hist;
    logic       r_sda_sync1, r_sda_sync2, r_sda_hist;
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_taken;
    logic       r_busy;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
    logic [7:0] w_shift_next;

    assign w_scl_rise   = r_scl_sync2 & ~r_scl_hist;
    assign w_scl_fall   = ~r_scl_sync2 & r_scl_hist;
    // SCL must be high on both samples so an SCL edge never masquerades as START/STOP
    assign w_start      = r_scl_sync2 & r_scl_hist & r_sda_hist & ~r_sda_sync2;
    assign w_stop       = r_scl_sync2 & r_scl_hist & ~r_sda_hist & r_sda_sync2;
    assign w_last_bit   = (r_bit_cnt == 4'd7);
    assign w_shift_next = {r_shift[6:0], r_sda_sync2};

    assign bus.sda_oe   = r_sda_oe;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_taken = r_tx_taken;
    assign bus.busy     = r_busy;

    // Synchronise the bus lines and keep one history sample for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync1 <= 1'b1;
            r_scl_sync2 <= 1'b1;
            r_scl_hist  <= 1'b1;
            r_sda_sync1 <= 1'b1;
            r_sda_sync2 <= 1'b1;
            r_sda_hist  <= 1'b1;
        end else begin
            r_scl_sync1 <= bus.scl_in;
            r_scl_sync2 <= r_scl_sync1;
            r_scl_hist  <= r_scl_sync2;
            r_sda_sync1 <= bus.sda_in;
            r_sda_sync2 <= r_sda_sync1;
            r_sda_hist  <= r_sda_sync2;
        end
    end

    // Protocol FSM: START/STOP override everything, otherwise step on SCL edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_taken <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_taken <= 1'b0;
            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_next;
                            if (w_last_bit) begin
                                r_bit_cnt <= 4'd0;
                                // r_shift[6:0] holds the address; the live sample is R/W
                                if (r_shift[6:0] == TARGET_ADDR) begin
                                    r_rw    <= r_sda_sync2;
                                    r_busy  <= 1'b1;
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_state <= ST_WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // bit counter 0: waiting to drive ACK; 1: ACK on the bus
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_sda_oe  <= 1'b1;
                                r_bit_cnt <= 4'd1;
                            end else begin
                                r_bit_cnt <= 4'd0;
                                if (r_rw) begin
                                    r_shift    <= bus.tx_data;
                                    r_tx_taken <= 1'b1;
                                    r_sda_oe   <= ~bus.tx_data[7];
                                    r_state    <= ST_TX;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= ST_RX;
                                end
                            end
                        end
                    end
                    ST_RX: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_next;
                            if (w_last_bit) begin
                                r_bit_cnt  <= 4'd0;
                                r_rx_data  <= w_shift_next;
                                r_rx_valid <= 1'b1;
                                r_state    <= ST_RX_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RX_ACK: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_sda_oe  <= 1'b1;
                                r_bit_cnt <= 4'd1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_RX;
                            end
                        end
                    end
                    ST_TX: begin
                        if (w_scl_fall) begin
                            if (w_last_bit) begin
                                r_bit_cnt <= 4'd0;
                                r_sda_oe  <= 1'b0;
                                r_state   <= ST_TX_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_sda_oe  <= ~r_shift[6];
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        // controller's ACK/NACK lands in r_shift[0]; counter marks it sampled
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                            r_bit_cnt <= 4'd0;
                            if (!r_shift[0]) begin
                                r_shift    <= bus.tx_data;
                                r_tx_taken <= 1'b1;
                                r_sda_oe   <= ~bus.tx_data[7];
                                r_state    <= ST_TX;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on a wired-AND SDA
// line, with pulse/level monitors sampled on the falling clk edge.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_sda;
    logic       tb_scl;
    logic [7:0] tb_tx;
    int         n_vec = 0;
    int         n_err = 0;
    int         rx_pulses = 0;
    int         tx_pulses = 0;
    int         oe_cycles = 0;
    int         busy_cycles = 0;
    int         both_cycles = 0;

    i2c_target_if bus ();
    assign bus.sda_in  = tb_sda & ~bus.sda_oe;
    assign bus.scl_in  = tb_scl;
    assign bus.tx_data = tb_tx;

    i2c_target #(.TARGET_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Count output pulses and active cycles for later comparison.
    always @(negedge clk) begin
        if (bus.rx_valid) rx_pulses <= rx_pulses + 1;
        if (bus.tx_taken) tx_pulses <= tx_pulses + 1;
        if (bus.sda_oe) oe_cycles <= oe_cycles + 1;
        if (bus.busy) busy_cycles <= busy_cycles + 1;
        if (bus.rx_valid && bus.tx_taken) both_cycles <= both_cycles + 1;
    end

    // Abort a runaway simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        tb_sda = 1'b1; cyc(4);
        tb_scl = 1'b1; cyc(8);
        tb_sda = 1'b0; cyc(8);
        tb_scl = 1'b0; cyc(4);
    endtask

    task automatic i2c_stop;
        tb_sda = 1'b0; cyc(4);
        tb_scl = 1'b1; cyc(8);
        tb_sda = 1'b1; cyc(8);
    endtask

    task automatic clock_bit(input logic b, output logic line);
        tb_sda = b;    cyc(4);
        tb_scl = 1'b1; cyc(4);
        line = bus.sda_in; cyc(4);
        tb_scl = 1'b0; cyc(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], l);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, l);
            d[i] = l;
        end
        tb_tx = next_tx;
        clock_bit(ack_bit, l);
    endtask

    task automatic test_reset;
        rst = 1'b1; tb_sda = 1'b1; tb_scl = 1'b1; tb_tx = 8'h00;
        cyc(4);
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
        n_vec++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        n_vec++; if (bus.tx_taken !== 1'b0) begin n_err++; $display("FAIL reset_tx_taken: got %b want 0", bus.tx_taken); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        cyc(8);
    endtask

    task automatic test_write;
        logic a0, a1;
        int rx0;
        rx0 = rx_pulses;
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'h3C, a1);
        n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL wr_addr_ack: got %b want 0", a0); end
        n_vec++; if (a1 !== 1'b0) begin n_err++; $display("FAIL wr_data_ack: got %b want 0", a1); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_before_stop: got %b want 1", bus.busy); end
        i2c_stop;
        n_vec++; if (bus.rx_data !== 8'h3C) begin n_err++; $display("FAIL wr_rx_data: got %h want 3c", bus.rx_data); end
        n_vec++; if (rx_pulses - rx0 !== 1) begin n_err++; $display("FAIL wr_rx_pulses: got %0d want 1", rx_pulses - rx0); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after_stop: got %b want 0", bus.busy); end
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL wr_sda_oe_after_stop: got %b want 0", bus.sda_oe); end
    endtask

    task automatic test_read;
        logic a0;
        logic [7:0] d0, d1, d2;
        int tx0, both0;
        tx0 = tx_pulses; both0 = both_cycles;
        tb_tx = 8'h5A;
        i2c_start;
        write_byte(8'hA1, a0);
        read_byte(1'b0, 8'h81, d0);
        read_byte(1'b0, 8'hFF, d1);
        read_byte(1'b1, 8'h00, d2);
        n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b want 0", a0); end
        n_vec++; if (d0 !== 8'h5A) begin n_err++; $display("FAIL rd_byte0: got %h want 5a", d0); end
        n_vec++; if (d1 !== 8'h81) begin n_err++; $display("FAIL rd_byte1: got %h want 81", d1); end
        n_vec++; if (d2 !== 8'hFF) begin n_err++; $display("FAIL rd_byte2: got %h want ff", d2); end
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_oe_after_nack: got %b want 0", bus.sda_oe); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_before_stop: got %b want 1", bus.busy); end
        i2c_stop;
        n_vec++; if (tx_pulses - tx0 !== 3) begin n_err++; $display("FAIL rd_tx_pulses: got %0d want 3", tx_pulses - tx0); end
        n_vec++; if (both_cycles - both0 !== 0) begin n_err++; $display("FAIL rd_pulse_overlap: got %0d want 0", both_cycles - both0); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_after_stop: got %b want 0", bus.busy); end
    endtask

    task automatic test_mismatch;
        logic a0, a1;
        int rx0, oe0, bz0;
        rx0 = rx_pulses; oe0 = oe_cycles; bz0 = busy_cycles;
        i2c_start;
        write_byte(8'hA2, a0);
        write_byte(8'h11, a1);
        i2c_stop;
        n_vec++; if (a0 !== 1'b1) begin n_err++; $display("FAIL mm_addr_nack: got %b want 1", a0); end
        n_vec++; if (a1 !== 1'b1) begin n_err++; $display("FAIL mm_data_nack: got %b want 1", a1); end
        n_vec++; if (oe_cycles - oe0 !== 0) begin n_err++; $display("FAIL mm_oe_cycles: got %0d want 0", oe_cycles - oe0); end
        n_vec++; if (rx_pulses - rx0 !== 0) begin n_err++; $display("FAIL mm_rx_pulses: got %0d want 0", rx_pulses - rx0); end
        n_vec++; if (busy_cycles - bz0 !== 0) begin n_err++; $display("FAIL mm_busy_cycles: got %0d want 0", busy_cycles - bz0); end
    endtask

    task automatic test_repeated_start;
        logic a0, a1, a2;
        logic [7:0] d0;
        int tx0;
        tx0 = tx_pulses;
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'h07, a1);
        tb_tx = 8'hC3;
        i2c_start;
        write_byte(8'hA1, a2);
        read_byte(1'b1, 8'h00, d0);
        i2c_stop;
        n_vec++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL sr_acks: got %b want 000", {a0, a1, a2}); end
        n_vec++; if (bus.rx_data !== 8'h07) begin n_err++; $display("FAIL sr_rx_data: got %h want 07", bus.rx_data); end
        n_vec++; if (d0 !== 8'hC3) begin n_err++; $display("FAIL sr_read_byte: got %h want c3", d0); end
        n_vec++; if (tx_pulses - tx0 !== 1) begin n_err++; $display("FAIL sr_tx_pulses: got %0d want 1", tx_pulses - tx0); end
    endtask

    task automatic test_reset_mid;
        logic l, a0;
        int oe0, rx0;
        i2c_start;
        clock_bit(1'b1, l); clock_bit(1'b0, l); clock_bit(1'b1, l); clock_bit(1'b0, l);
        rst = 1'b1;
        cyc(3);
        n_vec++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL rm_rx_data: got %h want 00", bus.rx_data); end
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rm_sda_oe: got %b want 0", bus.sda_oe); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        cyc(4);
        oe0 = oe_cycles; rx0 = rx_pulses;
        for (int i = 0; i < 4; i++) clock_bit(1'b0, l);
        clock_bit(1'b1, l);
        n_vec++; if (oe_cycles - oe0 !== 0) begin n_err++; $display("FAIL rm_ignored_oe: got %0d want 0", oe_cycles - oe0); end
        n_vec++; if (rx_pulses - rx0 !== 0) begin n_err++; $display("FAIL rm_ignored_rx: got %0d want 0", rx_pulses - rx0); end
        i2c_start;
        write_byte(8'hA0, a0);
        i2c_stop;
        n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL rm_next_ack: got %b want 0", a0); end
    endtask

    task automatic test_early_stop;
        logic a0, l;
        int rx0;
        i2c_start;
        write_byte(8'hA0, a0);
        rx0 = rx_pulses;
        clock_bit(1'b0, l); clock_bit(1'b0, l); clock_bit(1'b1, l); clock_bit(1'b1, l); clock_bit(1'b1, l);
        i2c_stop;
        n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL es_addr_ack: got %b want 0", a0); end
        n_vec++; if (rx_pulses - rx0 !== 0) begin n_err++; $display("FAIL es_rx_pulses: got %0d want 0", rx_pulses - rx0); end
        n_vec++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL es_rx_data: got %h want 00", bus.rx_data); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL es_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL es_sda_oe: got %b want 0", bus.sda_oe); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_mismatch;
        test_repeated_start;
        test_reset_mid;
        test_early_stop;
        cyc(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
